instr_loader: RTL and testbench

Writer-side counterpart to the instruction ROM. It accepts a stream of 9-bit machine-code words and writes them into the writable instruction memory starting at a given base address. It holds the processor in reset while loading and flags completion. It sits between the host/testbench stream source and the instruction memory write port, so programs can be reloaded without re-elaborating the memory file.

---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/instr_loader_cksum.sv | 19 +
 rtl/instr_loader.sv | 115 +++++++++++
 tb/tb_instr_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and default widths for the instruction loader.
package instr_loader_pkg;

  localparam int unsigned LDR_ADDR_W = 16;
  localparam int unsigned LDR_DATA_W = 9;
  localparam int unsigned LDR_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_loader_cksum.sv
// XOR accumulator over the loaded instruction words; clear has priority over enable.
module loader_cksum #(
  parameter int unsigned DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q ^ d;
  end

endmodule

// File: rtl/instr_loader.sv
// Streams instruction words into the writable instruction memory, holding the CPU in reset meanwhile.
// Define LOADER_CHECKSUM_EN to consume and verify a trailing XOR checksum word per load.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = LDR_ADDR_W,
  parameter int unsigned DATA_W = LDR_DATA_W,
  parameter int unsigned LEN_W  = LDR_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;
  logic              beat, data_beat, take_start, last;

  // Handshake decoded from registered state only, so in_valid never loops back to in_ready.
  assign in_ready   = (state == LOAD) || (state == CHECK);
  assign beat       = in_valid && in_ready;
  assign data_beat  = beat && (state == LOAD);
  assign take_start = start && ((state == IDLE) || (state == DONE));
  assign last       = (cnt == LEN_W'(1));

  assign busy     = in_ready;
  assign cpu_hold = in_ready;
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (length == '0) ? DONE : LOAD;
      end
      LOAD: begin
`ifdef LOADER_CHECKSUM_EN
        if (data_beat && last) state_nxt = CHECK;
`else
        if (data_beat && last) state_nxt = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (beat) state_nxt = DONE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= '0;
      cnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= data_beat;
      if (take_start) begin
        ptr <= base_addr;
        cnt <= length;
      end else if (data_beat) begin
        wr_addr <= ptr;
        wr_data <= in_data;
        ptr     <= ptr + ADDR_W'(1);
        cnt     <= cnt - LEN_W'(1);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] cksum;
  logic              err_q;

  loader_cksum #(.DATA_W(DATA_W)) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr   (take_start),
    .en    (data_beat),
    .d     (in_data),
    .q     (cksum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_q <= 1'b0;
    else if (take_start)                err_q <= 1'b0;
    else if (beat && (state == CHECK))  err_q <= (in_data != cksum);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader; follows LOADER_CHECKSUM_EN like the design.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_ready, wr_en, busy, done, err, cpu_hold;
  logic [15:0] wr_addr;
  logic [8:0]  wr_data;

  instr_loader #(.ADDR_W(16), .DATA_W(9), .LEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [8:0]  data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [8:0]  ld_words[0:63];
  bit          pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, in the cycle after its beat.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {7'd0, wr_data, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("missing_write", 32'd0, {7'd0, e.data, e.addr});
    end
  end

  // mode: 0 continuous valid, 1 repeating 1,0,0,1,1 pattern, 2 random valid
  task automatic run_load(input logic [15:0] base, input int unsigned len, input logic [8:0] ck,
                          input int unsigned mode, input bit mid_start);
    logic [8:0]  x;
    int unsigned total, sent, iter;
    bit          v, exp_err;
    wr_t         e;
    x = '0;
    for (int unsigned i = 0; i < len; i++) x ^= ld_words[i];
`ifdef LOADER_CHECKSUM_EN
    total   = (len == 0) ? 0 : len + 1;
    exp_err = (len != 0) && (ck != x);
`else
    total   = len;
    exp_err = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len[15:0]; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_hold", cpu_hold, 0);
      chk("len0_err", err, 0);
      return;
    end
    chk("busy_rise", busy, 1);
    chk("hold_rise", cpu_hold, 1);
    chk("done_clear", done, 0);
    sent = 0;
    iter = 0;
    while (sent < total && iter < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = pat[iter % 5];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (mid_start && iter == 1) begin
        start = 1'b1; base_addr = ~base; length = 16'd7;
      end else begin
        start = 1'b0; base_addr = base; length = len[15:0];
      end
      in_valid = v;
      in_data  = (sent < len) ? ld_words[sent] : ck;
      chk("in_ready_load", in_ready, 1);
      if (v) begin
        if (sent < len) begin
          e.addr = base + 16'(sent);
          e.data = ld_words[sent];
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
        sent++;
      end
      iter++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (sent < total) chk("load_timeout", sent, total);
    chk("done_rise", done, 1);
    chk("busy_fall", busy, 0);
    chk("hold_fall", cpu_hold, 0);
    chk("ready_idle", in_ready, 0);
    chk("err", err, exp_err);
    @(negedge clk);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b;
    int unsigned l;
    logic [8:0]  xs;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    ld_words[0] = 9'h1A5; ld_words[1] = 9'h003; ld_words[2] = 9'h1FF;
    run_load(16'h0010, 3, 9'h059, 0, 1'b0);
    run_load(16'h0010, 3, 9'h000, 0, 1'b0);

    for (int i = 0; i < 3; i++) ld_words[i] = 9'($urandom);
    xs = ld_words[0] ^ ld_words[1] ^ ld_words[2];
    run_load(16'hFFFE, 3, xs, 0, 1'b0);

    run_load(16'h1234, 0, 9'h000, 0, 1'b0);

    for (int i = 0; i < 3; i++) ld_words[i] = 9'($urandom);
    xs = ld_words[0] ^ ld_words[1] ^ ld_words[2];
    run_load(16'h0200, 3, xs, 1, 1'b1);

    // Reset after two of four words: outputs drop at once, remaining words never land.
    for (int i = 0; i < 4; i++) ld_words[i] = 9'($urandom);
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0100; length = 16'd4;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      wr_t e;
      in_valid = 1'b1; in_data = ld_words[i];
      e.addr = 16'h0100 + 16'(i); e.data = ld_words[i]; e.cyc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hold", cpu_hold, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_pending", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    xs = ld_words[0] ^ ld_words[1] ^ ld_words[2] ^ ld_words[3];
    run_load(16'h0100, 4, xs, 0, 1'b0);
    #1 reset = 1'b1;
    #1 chk("reset_clears_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(1, 12);
      b = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFF8 + 16'($urandom_range(0, 7));
      xs = '0;
      for (int unsigned i = 0; i < l; i++) begin
        ld_words[i] = 9'($urandom);
        xs ^= ld_words[i];
      end
      if ($urandom_range(0, 1) == 1) xs = 9'($urandom);
      run_load(b, l, xs, $urandom_range(0, 2), ($urandom_range(0, 1) == 1));
    end

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
